// File: rtl/tx_arbiter_if.sv
// Handshake bundle between the flit sources / TX handshake unit and the arbiter.
// The arbiter uses the slave modport; the surrounding logic uses master.
interface tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int DATA_W  = 55
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      tx_ready;
  logic                      rc_has_data;
  logic [DATA_W-1:0]         data_to_tx;
  logic [IDX_W-1:0]          cur_id;
  logic                      busy;
  logic                      tx_err;

  modport master (
    output req, req_data, tx_ready,
    input  grant, rc_has_data, data_to_tx, cur_id, busy, tx_err
  );

  modport slave (
    input  req, req_data, tx_ready,
    output grant, rc_has_data, data_to_tx, cur_id, busy, tx_err
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing the router-core TX handshake unit between flit sources.
// A captured flit is held until accepted, then the arbiter waits for the transfer to start.
module tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int DATA_W      = 55,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic         clk,
  input logic         rst_n,
  tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    cur_id_q, cur_id_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                rc_has_data_q, rc_has_data_d;
  logic                busy_q, busy_d;
  logic                tx_err_q, tx_err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         to_cnt_q, to_cnt_d;

  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    win_idx;
  logic                found;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan rr_ptr+1 .. rr_ptr+NUM_REQ with explicit wrap so non-power-of-two counts work.
  always_comb begin
    scan_idx = rr_ptr_q;
    win_idx  = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (scan_idx == IDX_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!found && bus.req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cur_id_d      = cur_id_q;
    grant_d       = '0;
    rc_has_data_d = rc_has_data_q;
    busy_d        = busy_q;
    tx_err_d      = tx_err_q;
    data_d        = data_q;
    to_cnt_d      = to_cnt_q;
    case (state_q)
      IDLE: begin
        rc_has_data_d = 1'b0;
        busy_d        = 1'b0;
        if (bus.tx_ready && found) begin
          data_d           = data_arr[win_idx];
          cur_id_d         = win_idx;
          grant_d[win_idx] = 1'b1;
          rr_ptr_d         = win_idx;
          rc_has_data_d    = 1'b1;
          busy_d           = 1'b1;
          state_d          = SEND;
        end
      end
      SEND: begin
        rc_has_data_d = 1'b1;
        busy_d        = 1'b1;
        if (bus.tx_ready) begin
          rc_has_data_d = 1'b0;
          to_cnt_d      = '0;
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        rc_has_data_d = 1'b0;
        busy_d        = 1'b1;
        // tx_ready falling means the TX unit has started shifting the flit out.
        if (!bus.tx_ready) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (to_cnt_q + 16'd1 == 16'(TIMEOUT_CYC)) begin
          tx_err_d = 1'b1;
          busy_d   = 1'b0;
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      default: begin
        rc_has_data_d = 1'b0;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      cur_id_q      <= '0;
      grant_q       <= '0;
      rc_has_data_q <= 1'b0;
      busy_q        <= 1'b0;
      tx_err_q      <= 1'b0;
      data_q        <= '0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_id_q      <= cur_id_d;
      grant_q       <= grant_d;
      rc_has_data_q <= rc_has_data_d;
      busy_q        <= busy_d;
      tx_err_q      <= tx_err_d;
      data_q        <= data_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.rc_has_data = rc_has_data_q;
  assign bus.data_to_tx  = data_q;
  assign bus.cur_id      = cur_id_q;
  assign bus.busy        = busy_q;
  assign bus.tx_err      = tx_err_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: capture, stall, rotation, dropped request,
// DRAIN timeout and asynchronous reset in the middle of SEND.
module tb_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int DATA_W  = 55;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  tx_arbiter #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [DATA_W-1:0] v);
    bus.req_data[i*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_ready = 1'b0;
    tick();
    tick();
    chk("rst_grant", 64'(bus.grant), 64'h0);
    chk("rst_rc", 64'(bus.rc_has_data), 64'h0);
    chk("rst_data", 64'(bus.data_to_tx), 64'h0);
    chk("rst_cur_id", 64'(bus.cur_id), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_tx_err", 64'(bus.tx_err), 64'h0);
    rst_n = 1'b1;

    // Single request from source 2
    bus.tx_ready = 1'b1;
    bus.req      = 4'b0100;
    set_data(2, 55'h1A5);
    tick();
    chk("t1_grant", 64'(bus.grant), 64'h4);
    chk("t1_rc", 64'(bus.rc_has_data), 64'h1);
    chk("t1_data", 64'(bus.data_to_tx), 64'h1A5);
    chk("t1_cur_id", 64'(bus.cur_id), 64'h2);
    chk("t1_busy", 64'(bus.busy), 64'h1);
    bus.req = 4'b0000;
    tick();
    chk("t1_grant_off", 64'(bus.grant), 64'h0);
    chk("t1_rc_accept", 64'(bus.rc_has_data), 64'h0);
    chk("t1_busy_drain", 64'(bus.busy), 64'h1);
    bus.tx_ready = 1'b0;
    tick();
    chk("t1_busy_idle", 64'(bus.busy), 64'h0);

    // Stall in SEND for 10 cycles; winner's data changes after grant
    bus.tx_ready = 1'b1;
    bus.req      = 4'b0010;
    set_data(1, 55'h7_1234_5678);
    tick();
    chk("t3_grant", 64'(bus.grant), 64'h2);
    chk("t3_cur_id", 64'(bus.cur_id), 64'h1);
    bus.tx_ready = 1'b0;
    set_data(1, 55'h0_DEAD_BEEF);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t3_rc_hold", 64'(bus.rc_has_data), 64'h1);
      chk("t3_data_hold", 64'(bus.data_to_tx), 64'h7_1234_5678);
      chk("t3_no_grant", 64'(bus.grant), 64'h0);
    end
    bus.req      = 4'b0000;
    bus.tx_ready = 1'b1;
    tick();
    chk("t3_rc_accept", 64'(bus.rc_has_data), 64'h0);
    bus.tx_ready = 1'b0;
    tick();
    chk("t3_idle", 64'(bus.busy), 64'h0);

    // Asynchronous reset while in SEND
    bus.tx_ready = 1'b1;
    bus.req      = 4'b1000;
    set_data(3, 55'h333);
    tick();
    chk("t6_grant", 64'(bus.grant), 64'h8);
    bus.tx_ready = 1'b0;
    tick();
    chk("t6_rc_send", 64'(bus.rc_has_data), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rc_async", 64'(bus.rc_has_data), 64'h0);
    chk("t6_busy_async", 64'(bus.busy), 64'h0);
    chk("t6_data_async", 64'(bus.data_to_tx), 64'h0);
    bus.req = 4'b0000;
    tick();
    rst_n = 1'b1;

    // All sources requesting: rotation 0,1,2,3,0 with modelled TX handshake
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 55'(64'hAA0 + 64'(i)));
    bus.req      = 4'b1111;
    bus.tx_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t2_grant", 64'(bus.grant), 64'(1) << (g % 4));
      chk("t2_cur_id", 64'(bus.cur_id), 64'(g % 4));
      chk("t2_data", 64'(bus.data_to_tx), 64'hAA0 + 64'(g % 4));
      chk("t2_rc_on", 64'(bus.rc_has_data), 64'h1);
      tick();
      chk("t2_rc_off", 64'(bus.rc_has_data), 64'h0);
      chk("t2_grant_off", 64'(bus.grant), 64'h0);
      bus.tx_ready = 1'b0;
      for (int w = 0; w < 4; w++) begin
        tick();
        chk("t2_gap_rc", 64'(bus.rc_has_data), 64'h0);
        chk("t2_gap_grant", 64'(bus.grant), 64'h0);
      end
      bus.tx_ready = 1'b1;
    end
    bus.req = 4'b0000;

    // Source 1 drops its request before tx_ready returns
    bus.tx_ready = 1'b0;
    bus.req      = 4'b0010;
    tick();
    tick();
    bus.req = 4'b0000;
    tick();
    bus.tx_ready = 1'b1;
    tick();
    chk("t5_no_grant", 64'(bus.grant), 64'h0);
    chk("t5_rc", 64'(bus.rc_has_data), 64'h0);
    chk("t5_busy", 64'(bus.busy), 64'h0);

    // DRAIN timeout with TIMEOUT_CYC=8
    bus.req = 4'b0100;
    set_data(2, 55'h2);
    tick();
    chk("t4_grant", 64'(bus.grant), 64'h4);
    bus.req = 4'b0000;
    tick();
    chk("t4_rc_accept", 64'(bus.rc_has_data), 64'h0);
    chk("t4_err_pre", 64'(bus.tx_err), 64'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        chk("t4_err_wait", 64'(bus.tx_err), 64'h0);
        chk("t4_busy_wait", 64'(bus.busy), 64'h1);
      end else begin
        chk("t4_err_set", 64'(bus.tx_err), 64'h1);
        chk("t4_busy_idle", 64'(bus.busy), 64'h0);
      end
    end
    bus.req = 4'b0001;
    set_data(0, 55'h55);
    tick();
    chk("t4_next_grant", 64'(bus.grant), 64'h1);
    chk("t4_next_data", 64'(bus.data_to_tx), 64'h55);
    chk("t4_err_sticky", 64'(bus.tx_err), 64'h1);
    bus.req = 4'b0000;
    tick();
    bus.tx_ready = 1'b0;
    tick();
    chk("t4_final_idle", 64'(bus.busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
